mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported, variable-latency instruction/data memory between the IF stage (instruction fetch) and the MEM stage (load/store) of the five-stage pipeline. Sequences one memory transaction at a time with a req/ack handshake, gives MEM priority over IF, and drives the freeze signals (`pc_stall_o`, `if_id_hold_o`, `pipe_stall_o`) that hold the pipeline while an access is outstanding. It sits between the stage request ports and the memory model, alongside the hazard detection unit, whose stall outputs are OR-ed with these at the top level.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYC`, 64, max ack wait in cycles; used only with `ARB_TIMEOUT_EN`; legal range 1..255

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge
- `rst_i`  in  1  asynchronous active-low reset
- `if_req_i`  in  1  IF read request; held until `if_ready_o`
- `if_addr_i`  in  ADDR_W  fetch address (PC)
- `if_rdata_o`  out  DATA_W  fetched instruction, registered
- `if_ready_o`  out  1  one-cycle pulse: `if_rdata_o` valid
- `dm_req_i`  in  1  MEM request (MemRead | MemWrite); held until `dm_ready_o`
- `dm_we_i`  in  1  1 = store, 0 = load
- `dm_addr_i`  in  ADDR_W  data address
- `dm_wdata_i`  in  DATA_W  store data
- `dm_rdata_o`  out  DATA_W  load data, registered
- `dm_ready_o`  out  1  one-cycle pulse: data access complete
- `mem_req_o`  out  1  memory request, held until ack
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  ADDR_W  memory address
- `mem_wdata_o`  out  DATA_W  memory write data
- `mem_rdata_i`  in  DATA_W  memory read data, valid with ack
- `mem_ack_i`  in  1  one-cycle completion pulse
- `pc_stall_o`  out  1  hold PC
- `if_id_hold_o`  out  1  hold the IF/ID register
- `pipe_stall_o`  out  1  freeze ID/EX, EX/MEM and MEM/WB
- `err_o`  out  1  sticky timeout flag (0 without the macro)

## Operation
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE: if `dm_req_i` and not `dm_ready_o`, latch `dm_we_i`/`dm_addr_i`/`dm_wdata_i` into the `mem_*` registers, set `mem_req_o`=1 and go to DM_BUSY. Otherwise, if `if_req_i` and not `if_ready_o`, latch `if_addr_i`, set `mem_we_o`=0 and `mem_req_o`=1, and go to IF_BUSY. Otherwise stay in IDLE.
- Simultaneous IF and MEM requests: MEM wins. IF is served on the next IDLE cycle.
- A requester whose ready pulse is high in the current cycle is not granted in that cycle. This blocks a re-issue of the request being retired.
- IF_BUSY/DM_BUSY: `mem_*` outputs are held stable. On `mem_ack_i`: `mem_req_o`←0, the matching rdata register ← `mem_rdata_i` (loads and fetches only; a store leaves `dm_rdata_o` unchanged), the matching ready ←1 for exactly one cycle, state ← IDLE.
- `mem_ack_i` in IDLE is ignored, including an ack that arrives after a mid-transaction reset.
- Stall outputs are combinational from the registered state and the inputs:
  - `pipe_stall_o` = `dm_req_i` & ~`dm_ready_o`
  - `pc_stall_o` = `if_id_hold_o` = `pipe_stall_o` | (`if_req_i` & ~`if_ready_o`)
- Reset: state IDLE; all `mem_*` outputs, rdata registers, ready outputs and `err_o` are 0. Stall outputs follow their equations.

## Timing
- Grant latency: a request seen in IDLE at edge N drives `mem_req_o`=1 after edge N.
- Ack seen at edge M: ready=1 during cycle M..M+1, and the rdata register is valid from M onward.
- Minimum transaction: 2 cycles from request to ready, with zero-wait memory (ack in the first request cycle).
- Back-to-back MEM then IF: the IF grant occurs at the edge where `dm_ready_o` is high, so there are no idle bubbles.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on grant and increments each BUSY cycle without ack.
  - When it reaches `TIMEOUT_CYC`: `mem_req_o`←0, the pending ready pulses, its rdata register ← all-ones, `err_o`←1 (sticky until reset), state ← IDLE.
  - A late ack arriving in IDLE is ignored.
- Not defined: there is no counter, BUSY waits indefinitely, and `err_o` is tied to 0.

## Test plan
- Reset mid-DM_BUSY, then ack: `mem_req_o`=0 immediately; the ack is ignored; no ready pulse.
- IF fetch at 0x0000_0040, ack after 3 cycles with 0x8C22_0004: `if_rdata_o`=0x8C22_0004, `if_ready_o` high for 1 cycle, `pc_stall_o` high for 4 cycles.
- IF and load (addr 0x100) requested in the same cycle: load granted first (`mem_we_o`=0, addr 0x100); fetch granted at the edge where `dm_ready_o` pulses; `pipe_stall_o` drops with `dm_ready_o`.
- Store to 0x200 of 0xDEAD_0001, zero-wait ack: `mem_we_o`=1, `mem_wdata_o`=0xDEAD_0001; `dm_ready_o` pulses on cycle 2; `dm_rdata_o` unchanged.
- `ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=4, no ack: after 4 BUSY cycles, `err_o`=1, ready pulses, rdata=0xFFFF_FFFF; a later ack is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store; MEM has priority.
// Define ARB_TIMEOUT_EN for the ack-wait timeout with sticky err_o.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              pc_stall_o,
  output logic              if_id_hold_o,
  output logic              pipe_stall_o,
  output logic              err_o
);

  // state   | meaning
  // IDLE    | no access outstanding, arbitrate pending requests
  // IF_BUSY | fetch issued to memory, waiting for ack
  // DM_BUSY | load/store issued to memory, waiting for ack
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t state;
  logic   if_pend;
  logic   dm_pend;
  logic   timeout;

  // The ready term masks the request being retired this cycle.
  assign dm_pend      = dm_req_i & ~dm_ready_o;
  assign if_pend      = if_req_i & ~if_ready_o;
  assign pipe_stall_o = dm_pend;
  assign pc_stall_o   = dm_pend | if_pend;
  assign if_id_hold_o = pc_stall_o;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wait_cnt;

  assign timeout = (state != IDLE) && !mem_ack_i && (wait_cnt == TMO_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (!mem_ack_i) begin
        wait_cnt <= wait_cnt + 8'd1;
        if (timeout) err_o <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ready_o  <= 1'b0;
    end else begin
      if_ready_o <= 1'b0;
      dm_ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_pend) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            state       <= DM_BUSY;
          end else if (if_pend) begin
            mem_req_o  <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_addr_o <= if_addr_i;
            state      <= IF_BUSY;
          end
        end
        IF_BUSY: begin
          if (mem_ack_i || timeout) begin
            mem_req_o  <= 1'b0;
            if_rdata_o <= mem_ack_i ? mem_rdata_i : '1;
            if_ready_o <= 1'b1;
            state      <= IDLE;
          end
        end
        DM_BUSY: begin
          if (mem_ack_i || timeout) begin
            mem_req_o <= 1'b0;
            if (!mem_ack_i) dm_rdata_o <= '1;
            else if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
            dm_ready_o <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: memory model with programmable ack latency,
// expected memory transactions and ready data queued at stimulus, popped at ack/ready.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          if_req_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0;
  logic [DW-1:0] if_rdata_o;
  logic          if_ready_o;
  logic          dm_req_i = 1'b0;
  logic          dm_we_i = 1'b0;
  logic [AW-1:0] dm_addr_i = '0;
  logic [DW-1:0] dm_wdata_i = '0;
  logic [DW-1:0] dm_rdata_o;
  logic          dm_ready_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_ack_i = 1'b0;
  logic          pc_stall_o;
  logic          if_id_hold_o;
  logic          pipe_stall_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .pc_stall_o(pc_stall_o), .if_id_hold_o(if_id_hold_o), .pipe_stall_o(pipe_stall_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_mem[$];
  logic [DW-1:0] exp_if[$];
  logic [DW-1:0] exp_dm[$];
  txn_t          mt;

  int lat    = 0;
  bit mem_en = 1'b1;
  bit stray  = 1'b0;
  int wcnt   = 0;
  int stall_cnt = 0;
  int if_rdy_cnt = 0;
  int dm_rdy_cnt = 0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    return (a == 32'h40) ? 32'h8C22_0004 : ((a ^ 32'h5A5A_0000) + 32'h11);
  endfunction

  // memory model: acks after lat wait cycles, checks the issued transaction
  always @(negedge clk_i) begin
    mem_ack_i = 1'b0;
    if (stray) begin
      mem_ack_i   = 1'b1;
      mem_rdata_i = 32'hBAD0_BAD0;
    end else if (mem_req_o && mem_en) begin
      if (wcnt >= lat) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rd_val(mem_addr_o);
        wcnt = 0;
        if (exp_mem.size() == 0) chk("mem_extra", 1, 0);
        else begin
          mt = exp_mem.pop_front();
          chk("mem_we", mem_we_o, mt.we);
          chk("mem_addr", mem_addr_o, mt.addr);
          if (mt.we) chk("mem_wdata", mem_wdata_o, mt.wdata);
        end
      end else wcnt++;
    end else wcnt = 0;
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      if (pc_stall_o) stall_cnt++;
      if (if_ready_o) begin
        if_rdy_cnt++;
        if (exp_if.size() == 0) chk("if_extra", 1, 0);
        else chk("if_rdata", if_rdata_o, exp_if.pop_front());
      end
      if (dm_ready_o) begin
        dm_rdy_cnt++;
        if (exp_dm.size() == 0) chk("dm_extra", 1, 0);
        else chk("dm_rdata", dm_rdata_o, exp_dm.pop_front());
      end
    end
  end

  task automatic exp_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    exp_mem.push_back(t);
  endtask

  task automatic run_if(input logic [AW-1:0] a, input logic [DW-1:0] exp, output int waited);
    exp_if.push_back(exp);
    @(posedge clk_i); #1;
    if_req_i = 1'b1; if_addr_i = a;
    waited = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (if_ready_o) begin waited = i; break; end
    end
    if (waited < 0) chk("if_wait_expired", 0, 1);
    @(posedge clk_i); #1;
    if_req_i = 1'b0; if_addr_i = $urandom;
  endtask

  task automatic run_dm(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] exp, output int waited);
    exp_dm.push_back(exp);
    @(posedge clk_i); #1;
    dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = a; dm_wdata_i = d;
    waited = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (dm_ready_o) begin waited = i; break; end
    end
    if (waited < 0) chk("dm_wait_expired", 0, 1);
    @(posedge clk_i); #1;
    dm_req_i = 1'b0; dm_we_i = $urandom; dm_addr_i = $urandom; dm_wdata_i = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2, base, base2;
    logic [DW-1:0] last_ld;
    logic [AW-1:0] a;
    bit seen;
    last_ld = '0;

    // reset values, stall equations live during reset
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rdy", {if_ready_o, dm_ready_o}, 0);
    chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", {pc_stall_o, if_id_hold_o, pipe_stall_o}, 0);
    dm_req_i = 1'b1; #1;
    chk("rst_stall_eq", {pc_stall_o, if_id_hold_o, pipe_stall_o}, 3'b111);
    dm_req_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b1;

    // reset mid DM_BUSY, then a stray ack
    mem_en = 1'b0;
    @(posedge clk_i); #1;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h300;
    repeat (3) @(negedge clk_i);
    chk("busy_req", mem_req_o, 1);
    chk("busy_addr", mem_addr_o, 32'h300);
    @(posedge clk_i); #1;
    rst_i = 1'b0; dm_req_i = 1'b0;
    #1 chk("rst_mid_req", mem_req_o, 0);
    @(posedge clk_i); #1 rst_i = 1'b1;
    base = dm_rdy_cnt;
    stray = 1'b1;
    @(posedge clk_i); #1 stray = 1'b0;
    repeat (4) @(posedge clk_i);
    @(negedge clk_i);
    chk("stray_no_ready", dm_rdy_cnt - base, 0);
    chk("stray_req", mem_req_o, 0);
    chk("stray_rdata", dm_rdata_o, 0);
    mem_en = 1'b1;

    // single fetch at 0x40, ack on the third busy edge
    lat = 2;
    exp_txn(1'b0, 32'h40, '0);
    base = stall_cnt; base2 = if_rdy_cnt;
    run_if(32'h40, 32'h8C22_0004, w);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("if_latency", w, 4);
    chk("if_stall_cycles", stall_cnt - base, 4);
    chk("if_ready_width", if_rdy_cnt - base2, 1);

    // simultaneous load and fetch: load first, fetch granted on the dm_ready edge
    lat = 1;
    exp_txn(1'b0, 32'h100, '0);
    exp_txn(1'b0, 32'h44, '0);
    last_ld = rd_val(32'h100);
    fork
      run_dm(1'b0, 32'h100, 32'h0, rd_val(32'h100), w);
      run_if(32'h44, rd_val(32'h44), w2);
      begin
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk_i);
          if (dm_ready_o) begin seen = 1'b1; break; end
        end
        chk("sim_dm_seen", seen, 1);
        chk("sim_pipe_drop", pipe_stall_o, 0);
        chk("sim_if_stalled", pc_stall_o, 1);
        @(negedge clk_i);
        chk("sim_if_grant", {mem_req_o, mem_we_o}, 2'b10);
        chk("sim_if_addr", mem_addr_o, 32'h44);
      end
    join

    // zero-wait store leaves dm_rdata alone
    lat = 0;
    exp_txn(1'b1, 32'h200, 32'hDEAD_0001);
    run_dm(1'b1, 32'h200, 32'hDEAD_0001, last_ld, w);
    chk("st_latency", w, 2);

    // mixed sequential traffic with random latencies
    for (int k = 0; k < 10; k++) begin
      lat = $urandom_range(0, 3);
      a = {$urandom_range(0, 255), 2'b00};
      case ($urandom_range(0, 2))
        0: begin
          exp_txn(1'b0, a, '0);
          run_if(a, rd_val(a), w);
          chk("mix_if_lat", w, lat + 2);
        end
        1: begin
          exp_txn(1'b0, a, '0);
          last_ld = rd_val(a);
          run_dm(1'b0, a, 32'h0, last_ld, w);
          chk("mix_ld_lat", w, lat + 2);
        end
        default: begin
          exp_txn(1'b1, a, 32'hC0DE_0000 | k);
          run_dm(1'b1, a, 32'hC0DE_0000 | k, last_ld, w);
          chk("mix_st_lat", w, lat + 2);
        end
      endcase
    end

`ifdef ARB_TIMEOUT_EN
    // no ack: timeout after TMO busy cycles, then a late ack is ignored
    mem_en = 1'b0;
    run_dm(1'b0, 32'h180, 32'h0, 32'hFFFF_FFFF, w);
    chk("tmo_latency", w, TMO + 1);
    chk("tmo_err", err_o, 1);
    base = dm_rdy_cnt;
    stray = 1'b1;
    @(posedge clk_i); #1 stray = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("tmo_late_ack", dm_rdy_cnt - base, 0);
    chk("tmo_err_sticky", err_o, 1);
    mem_en = 1'b1;
`else
    chk("err_tied", err_o, 0);
`endif

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("q_mem_left", exp_mem.size(), 0);
    chk("q_if_left", exp_if.size(), 0);
    chk("q_dm_left", exp_dm.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
